serv_irq_monitor: RTL and testbench
===================================

Name: serv_irq_monitor

Overview:
- Synthesisable, parametrised interrupt and fetch monitor for servant-class SoCs.
- Taps the CPU instruction-fetch bus and the CSR trap signals. Keeps a circular PC trace, per-cause interrupt counters and interrupt-to-vector latency statistics.
- Intended for both simulation benches and on-chip debug: a register-style readout port replaces hierarchical probing of CPU internals.

Parameters:
- DEPTH, 16, trace buffer entries; power of two, >=2.
- NUM_CAUSE, 16, number of cause counters, indexed by i_mcause; 1..16.
- NUM_IRQ, 1, number of watched raw interrupt request lines.
- CNT_W, 16, width of each cause counter (saturating).
- LAT_W, 12, width of the latency counter.

Ports:
- wb_clk  in  1  clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- i_clr  in  1  synchronous clear of all statistics, trace and FSM.
- i_pc_adr  in  32  fetch address.
- i_pc_vld  in  1  fetch acknowledge; the address is valid this cycle.
- i_new_irq  in  1  single-cycle pulse: CPU is taking a trap.
- i_mcause  in  4  trap cause (mcause[3:0]), valid with i_new_irq.
- i_irq_req  in  NUM_IRQ  raw interrupt request lines, level.
- i_mtvec  in  32  trap vector address, quasi-static.
- i_rd_en  in  1  trace read strobe.
- i_rd_idx  in  log2(DEPTH)  trace index; 0 = most recent entry.
- o_rd_data  out  33  {irq_flag, pc}; valid one cycle after i_rd_en.
- o_rd_vld  out  1  read data valid pulse.
- o_trace_cnt  out  log2(DEPTH)+1  number of valid entries; saturates at DEPTH.
- o_cause_cnt  out  NUM_CAUSE*CNT_W  flattened counters; cause k at bits [k*CNT_W +: CNT_W].
- o_lat_last  out  LAT_W  last measured latency.
- o_lat_max  out  LAT_W  maximum measured latency.
- o_lat_vld  out  1  one-cycle pulse when o_lat_last updates.
- o_lat_timeout  out  1  sticky; a measurement overflowed.

Behaviour:
- Reset:
  - All outputs, pointers, counters, edge registers and the armed flag reset to 0. FSM resets to IDLE.
  - Trace RAM contents are undefined after reset, but are never visible: o_trace_cnt=0 masks them.
- Trace:
  - Each i_pc_vld cycle writes {armed, i_pc_adr} at wr_ptr, then increments wr_ptr modulo DEPTH.
  - armed is set by i_new_irq and cleared by the next write, so the flag marks the first fetch after a trap.
  - If i_new_irq and i_pc_vld occur in the same cycle, that write has flag=0 and armed is set.
  - o_trace_cnt increments per write up to DEPTH, then holds.
  - A read returns the entry at (wr_ptr-1-i_rd_idx) mod DEPTH, sampled in the cycle of i_rd_en.
  - If i_rd_idx >= o_trace_cnt, o_rd_data=0.
  - Read and write in the same cycle: the read uses the pre-write pointer and contents.
- Cause counters:
  - On i_new_irq, counter[i_mcause] increments, saturating at all-ones.
  - If i_mcause >= NUM_CAUSE, no counter changes.
- Latency FSM (states IDLE, WAIT_TAKE, WAIT_VEC):
  - Edge detect: edge = |(i_irq_req & ~req_q), where req_q is the registered copy of i_irq_req.
  - IDLE: on edge, lat_cnt<=0. Go to WAIT_VEC if i_new_irq is also high this cycle, otherwise WAIT_TAKE. i_new_irq without an edge is counted only; no measurement starts.
  - WAIT_TAKE: lat_cnt increments each cycle. On i_new_irq, go to WAIT_VEC. Further edges are ignored; no nesting.
  - WAIT_VEC: lat_cnt increments each cycle. On i_pc_vld with i_pc_adr==i_mtvec: o_lat_last<=lat_cnt+1, o_lat_max<=max(o_lat_max, lat_cnt+1), o_lat_vld=1, go to IDLE. A fetch at any other address keeps waiting.
  - Result: recorded latency = (vector-ack cycle) minus (edge cycle).
  - In either WAIT state, if lat_cnt reaches all-ones before completion: set o_lat_timeout, go to IDLE, leave o_lat_last and o_lat_max unchanged.
- i_clr:
  - Zeroes all counters, latency outputs, timeout, o_trace_cnt, wr_ptr and armed. FSM goes to IDLE.
  - Takes priority over every same-cycle event: that cycle's fetch is not traced and that cycle's trap is not counted.
  - req_q still updates, so a level already high does not produce an edge after the clear.
- Reset asserted mid-measurement aborts it; no o_lat_vld pulse is produced.

Test Plan:
- Post-reset, 3 fetches at 0x100, 0x104, 0x108 -> o_trace_cnt=3. Reads of idx 0/1/2 -> 0x108/0x104/0x100, flag=0. Read of idx 3 -> 0.
- Edge on i_irq_req[0] at cycle 0, i_new_irq at cycle 4 with mcause=7, fetch of i_mtvec=0x20 at cycle 9 -> o_lat_last=9, o_lat_max=9, o_lat_vld pulse at cycle 10. counter[7]=1. The trace entry for 0x20 has flag=1.
- Second interrupt with latency 5 -> o_lat_last=5, o_lat_max stays 9. Then i_clr -> all statistics and o_trace_cnt read 0.
- LAT_W=4, edge with no trap taken -> o_lat_timeout=1 after 15 cycles, o_lat_vld never pulses, FSM accepts the next edge.
- DEPTH+5 fetches -> o_trace_cnt=DEPTH. Idx 0 returns the last PC, idx DEPTH-1 returns fetch number 6; wrap-around verified.
- CNT_W=2, 5 traps with mcause=3 -> counter[3]=3 (saturated). A trap with mcause=15 and NUM_CAUSE=8 leaves all counters unchanged. Asserting wb_rst_n low mid-WAIT_VEC returns the FSM to IDLE with no o_lat_vld pulse.

Source files
------------

// File: rtl/serv_irq_monitor.sv
// serv_irq_monitor: passive interrupt and fetch monitor for servant-class SoCs.
//
// Taps the instruction-fetch bus and CSR trap signals. It keeps:
//   - a circular PC trace, where each entry is {first-fetch-after-trap flag, pc},
//   - saturating per-cause trap counters,
//   - interrupt-edge to vector-fetch latency statistics (last, max, sticky timeout).
//
// Ports:
//   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//   i_clr                     synchronous clear of statistics, trace and FSM
//   i_pc_adr, i_pc_vld        fetch address and fetch acknowledge
//   i_new_irq, i_mcause       trap-taken pulse and its cause
//   i_irq_req                 raw interrupt request levels
//   i_mtvec                   trap vector address
//   i_rd_en, i_rd_idx         trace read strobe and index (0 = newest entry)
//   o_rd_data, o_rd_vld       trace read data {flag, pc}, valid one cycle later
//   o_trace_cnt               number of valid trace entries (saturates at DEPTH)
//   o_cause_cnt               flattened cause counters, cause k at [k*CNT_W +: CNT_W]
//   o_lat_last, o_lat_max     last and maximum measured latency
//   o_lat_vld                 pulse when o_lat_last updates
//   o_lat_timeout             sticky, set when a measurement overflows
module serv_irq_monitor #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned NUM_CAUSE = 16,
  parameter int unsigned NUM_IRQ   = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LAT_W     = 12
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst_n,
  input  logic                       i_clr,
  input  logic [31:0]                i_pc_adr,
  input  logic                       i_pc_vld,
  input  logic                       i_new_irq,
  input  logic [3:0]                 i_mcause,
  input  logic [NUM_IRQ-1:0]         i_irq_req,
  input  logic [31:0]                i_mtvec,
  input  logic                       i_rd_en,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
  output logic [32:0]                o_rd_data,
  output logic                       o_rd_vld,
  output logic [$clog2(DEPTH):0]     o_trace_cnt,
  output logic [NUM_CAUSE*CNT_W-1:0] o_cause_cnt,
  output logic [LAT_W-1:0]           o_lat_last,
  output logic [LAT_W-1:0]           o_lat_max,
  output logic                       o_lat_vld,
  output logic                       o_lat_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitTake, StWaitVec} state_e;

  // Trace storage is deliberately not reset; o_trace_cnt masks stale entries.
  logic [32:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    trace_cnt_q;
  logic           armed_q;
  logic [AW-1:0]  rd_ptr;
  logic [32:0]    rd_data_q;
  logic           rd_vld_q;

  logic [CNT_W-1:0] cnt_q [NUM_CAUSE];

  logic [NUM_IRQ-1:0] req_q;
  logic               irq_edge;
  state_e             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d, lat_inc;
  logic [LAT_W-1:0]   lat_last_q, lat_last_d, lat_max_q, lat_max_d;
  logic               lat_vld_q, lat_vld_d, timeout_q, timeout_d;
  logic               trace_wr;

  assign trace_wr = i_pc_vld & ~i_clr;
  assign rd_ptr   = wr_ptr_q - AW'(1) - i_rd_idx;
  assign irq_edge = |(i_irq_req & ~req_q);
  assign lat_inc  = lat_q + LAT_W'(1);

  // A trap in the same cycle as a fetch arms the flag for the next fetch instead.
  always_ff @(posedge wb_clk) begin
    if (trace_wr) begin
      mem_q[wr_ptr_q] <= {armed_q & ~i_new_irq, i_pc_adr};
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_q    <= '0;
      trace_cnt_q <= '0;
      armed_q     <= 1'b0;
      rd_data_q   <= '0;
      rd_vld_q    <= 1'b0;
    end else begin
      rd_vld_q <= i_rd_en;
      // Reads see pre-write pointer and contents.
      if (i_rd_en) begin
        rd_data_q <= ({1'b0, i_rd_idx} < trace_cnt_q) ? mem_q[rd_ptr] : '0;
      end
      if (i_clr) begin
        wr_ptr_q    <= '0;
        trace_cnt_q <= '0;
        armed_q     <= 1'b0;
      end else begin
        if (i_pc_vld) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          if (trace_cnt_q != (AW+1)'(DEPTH)) begin
            trace_cnt_q <= trace_cnt_q + (AW+1)'(1);
          end
        end
        if (i_new_irq) begin
          armed_q <= 1'b1;
        end else if (i_pc_vld) begin
          armed_q <= 1'b0;
        end
      end
    end
  end

  // Out-of-range causes match no counter and are silently dropped.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int k = 0; k < int'(NUM_CAUSE); k++) cnt_q[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < int'(NUM_CAUSE); k++) cnt_q[k] <= '0;
    end else if (i_new_irq) begin
      for (int k = 0; k < int'(NUM_CAUSE); k++) begin
        if (4'(k) == i_mcause && cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_cause_cnt = '0;
    for (int k = 0; k < int'(NUM_CAUSE); k++) begin
      o_cause_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
    end
  end

  // Latency FSM. lat_q holds (cycles since edge - 1), so lat_q + 1 at the vector
  // fetch is the edge-to-ack distance. An all-ones lat_q cannot be completed and
  // is treated as overflow.
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    lat_last_d = lat_last_q;
    lat_max_d  = lat_max_q;
    lat_vld_d  = 1'b0;
    timeout_d  = timeout_q;
    case (state_q)
      StIdle: begin
        if (irq_edge) begin
          lat_d   = '0;
          state_d = i_new_irq ? StWaitVec : StWaitTake;
        end
      end
      StWaitTake: begin
        if (lat_q == '1) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          lat_d = lat_inc;
          if (i_new_irq) state_d = StWaitVec;
        end
      end
      StWaitVec: begin
        if (lat_q == '1) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else if (i_pc_vld && i_pc_adr == i_mtvec) begin
          lat_last_d = lat_inc;
          lat_max_d  = (lat_inc > lat_max_q) ? lat_inc : lat_max_q;
          lat_vld_d  = 1'b1;
          state_d    = StIdle;
        end else begin
          lat_d = lat_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    if (i_clr) begin
      state_d    = StIdle;
      lat_d      = '0;
      lat_last_d = '0;
      lat_max_d  = '0;
      lat_vld_d  = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  // req_q keeps tracking during clear so a held level does not re-trigger.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      req_q      <= '0;
      state_q    <= StIdle;
      lat_q      <= '0;
      lat_last_q <= '0;
      lat_max_q  <= '0;
      lat_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      req_q      <= i_irq_req;
      state_q    <= state_d;
      lat_q      <= lat_d;
      lat_last_q <= lat_last_d;
      lat_max_q  <= lat_max_d;
      lat_vld_q  <= lat_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_rd_data     = rd_data_q;
  assign o_rd_vld      = rd_vld_q;
  assign o_trace_cnt   = trace_cnt_q;
  assign o_lat_last    = lat_last_q;
  assign o_lat_max     = lat_max_q;
  assign o_lat_vld     = lat_vld_q;
  assign o_lat_timeout = timeout_q;

endmodule

// File: tb/tb_serv_irq_monitor.sv
module tb_serv_irq_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: default parameters.
  logic        a_clr = 0, a_pc_vld = 0, a_new_irq = 0, a_rd_en = 0;
  logic [31:0] a_pc_adr = 0, a_mtvec = 32'h20;
  logic [3:0]  a_mcause = 0, a_rd_idx = 0;
  logic [0:0]  a_irq_req = 0;
  logic [32:0] a_rd_data;
  logic        a_rd_vld, a_lat_vld, a_lat_timeout;
  logic [4:0]  a_trace_cnt;
  logic [255:0] a_cause_cnt;
  logic [11:0] a_lat_last, a_lat_max;

  // Instance B: small counters for saturation and timeout.
  logic        b_clr = 0, b_pc_vld = 0, b_new_irq = 0, b_rd_en = 0;
  logic [31:0] b_pc_adr = 0, b_mtvec = 32'h40;
  logic [3:0]  b_mcause = 0;
  logic [1:0]  b_rd_idx = 0;
  logic [0:0]  b_irq_req = 0;
  logic [32:0] b_rd_data;
  logic        b_rd_vld, b_lat_vld, b_lat_timeout;
  logic [2:0]  b_trace_cnt;
  logic [15:0] b_cause_cnt;
  logic [3:0]  b_lat_last, b_lat_max;

  serv_irq_monitor u_a (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_clr(a_clr), .i_pc_adr(a_pc_adr), .i_pc_vld(a_pc_vld),
    .i_new_irq(a_new_irq), .i_mcause(a_mcause), .i_irq_req(a_irq_req), .i_mtvec(a_mtvec),
    .i_rd_en(a_rd_en), .i_rd_idx(a_rd_idx), .o_rd_data(a_rd_data), .o_rd_vld(a_rd_vld),
    .o_trace_cnt(a_trace_cnt), .o_cause_cnt(a_cause_cnt), .o_lat_last(a_lat_last),
    .o_lat_max(a_lat_max), .o_lat_vld(a_lat_vld), .o_lat_timeout(a_lat_timeout)
  );

  serv_irq_monitor #(.DEPTH(4), .NUM_CAUSE(8), .NUM_IRQ(1), .CNT_W(2), .LAT_W(4)) u_b (
    .wb_clk(clk), .wb_rst_n(rst_n), .i_clr(b_clr), .i_pc_adr(b_pc_adr), .i_pc_vld(b_pc_vld),
    .i_new_irq(b_new_irq), .i_mcause(b_mcause), .i_irq_req(b_irq_req), .i_mtvec(b_mtvec),
    .i_rd_en(b_rd_en), .i_rd_idx(b_rd_idx), .o_rd_data(b_rd_data), .o_rd_vld(b_rd_vld),
    .o_trace_cnt(b_trace_cnt), .o_cause_cnt(b_cause_cnt), .o_lat_last(b_lat_last),
    .o_lat_max(b_lat_max), .o_lat_vld(b_lat_vld), .o_lat_timeout(b_lat_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_read(input logic [3:0] idx, input logic [32:0] exp, input string tag);
    a_rd_en = 1; a_rd_idx = idx;
    tick();
    a_rd_en = 0;
    check({tag, "_vld"}, 64'(a_rd_vld), 64'd1);
    check(tag, 64'(a_rd_data), 64'(exp));
  endtask

  task automatic a_fetch(input logic [31:0] adr);
    a_pc_vld = 1; a_pc_adr = adr;
    tick();
    a_pc_vld = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_vld;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Reset state
    check("rst_trace_cnt", 64'(a_trace_cnt), 0);
    check("rst_cause", 64'(|a_cause_cnt), 0);
    check("rst_lat_last", 64'(a_lat_last), 0);
    check("rst_lat_max", 64'(a_lat_max), 0);
    check("rst_lat_vld", 64'(a_lat_vld), 0);
    check("rst_timeout", 64'(a_lat_timeout), 0);
    check("rst_rd_vld", 64'(a_rd_vld), 0);

    // Basic trace
    a_fetch(32'h100); a_fetch(32'h104); a_fetch(32'h108);
    check("trace_cnt3", 64'(a_trace_cnt), 3);
    a_read(0, 33'h0_00000108, "rd_idx0");
    a_read(1, 33'h0_00000104, "rd_idx1");
    a_read(2, 33'h0_00000100, "rd_idx2");
    a_read(3, 33'h0, "rd_idx3_empty");

    // Latency 9: edge c0, trap c4 cause 7, vector fetch c9
    a_irq_req = 1; tick();
    repeat (3) tick();
    a_new_irq = 1; a_mcause = 7; tick(); a_new_irq = 0;
    repeat (4) tick();
    check("lat_vld_early", 64'(a_lat_vld), 0);
    a_fetch(32'h20);
    check("lat9_vld", 64'(a_lat_vld), 1);
    check("lat9_last", 64'(a_lat_last), 9);
    check("lat9_max", 64'(a_lat_max), 9);
    tick();
    check("lat9_vld_pulse", 64'(a_lat_vld), 0);
    check("cause7", 64'(a_cause_cnt[7*16 +: 16]), 1);
    check("trace_cnt4", 64'(a_trace_cnt), 4);
    a_read(0, 33'h1_00000020, "rd_vec_flag");

    // Latency 5 with a non-vector fetch while waiting
    a_irq_req = 0; tick();
    a_irq_req = 1; tick();
    a_new_irq = 1; a_mcause = 2; tick(); a_new_irq = 0;
    tick();
    a_fetch(32'h44);
    tick();
    a_fetch(32'h20);
    check("lat5_vld", 64'(a_lat_vld), 1);
    check("lat5_last", 64'(a_lat_last), 5);
    check("lat5_max", 64'(a_lat_max), 9);
    check("cause2", 64'(a_cause_cnt[2*16 +: 16]), 1);
    check("cause7_hold", 64'(a_cause_cnt[7*16 +: 16]), 1);
    check("trace_cnt6", 64'(a_trace_cnt), 6);
    a_read(0, 33'h0_00000020, "rd_after_trap");
    a_read(1, 33'h1_00000044, "rd_first_after_trap");
    a_read(5, 33'h0_00000100, "rd_oldest");
    a_read(6, 33'h0, "rd_beyond_cnt");

    // Clear beats same-cycle fetch and trap
    a_clr = 1; a_new_irq = 1; a_mcause = 1; a_pc_vld = 1; a_pc_adr = 32'h500;
    tick();
    a_clr = 0; a_new_irq = 0; a_pc_vld = 0;
    check("clr_trace_cnt", 64'(a_trace_cnt), 0);
    check("clr_cause", 64'(|a_cause_cnt), 0);
    check("clr_lat_last", 64'(a_lat_last), 0);
    check("clr_lat_max", 64'(a_lat_max), 0);
    a_read(0, 33'h0, "clr_rd");
    // Held level after clear must not start a measurement
    tick();
    a_new_irq = 1; a_mcause = 0; tick(); a_new_irq = 0;
    a_fetch(32'h20);
    check("clr_no_edge", 64'(a_lat_vld), 0);
    check("cause0", 64'(a_cause_cnt[15:0]), 1);

    // Wrap-around: DEPTH+5 fetches
    for (int i = 0; i < 21; i++) a_fetch(32'h1000 + 32'(i * 4));
    check("wrap_cnt", 64'(a_trace_cnt), 16);
    a_read(0, 33'h0_00001050, "wrap_idx0");
    a_read(15, 33'h0_00001014, "wrap_idx15");

    // Reset mid-WAIT_VEC
    a_irq_req = 0; tick();
    a_irq_req = 1; a_new_irq = 1; tick();
    a_new_irq = 0; a_irq_req = 0;
    tick(); tick();
    rst_n = 0;
    #1;
    check("midrst_vld", 64'(a_lat_vld), 0);
    check("midrst_cnt", 64'(a_trace_cnt), 0);
    tick();
    rst_n = 1;
    tick();
    a_fetch(32'h20);
    check("postrst_no_vld", 64'(a_lat_vld), 0);
    check("postrst_last", 64'(a_lat_last), 0);
    a_irq_req = 1; a_new_irq = 1; tick();
    a_new_irq = 0;
    a_fetch(32'h20);
    check("postrst_lat1_vld", 64'(a_lat_vld), 1);
    check("postrst_lat1", 64'(a_lat_last), 1);

    // Instance B: timeout with LAT_W=4
    b_irq_req = 1; tick();
    tick();
    check("b_to_early", 64'(b_lat_timeout), 0);
    seen_vld = 0;
    for (int i = 0; i < 40 && !b_lat_timeout; i++) begin
      tick();
      if (b_lat_vld) seen_vld = 1;
    end
    check("b_timeout", 64'(b_lat_timeout), 1);
    check("b_no_vld", 64'(seen_vld), 0);
    check("b_last_hold", 64'(b_lat_last), 0);
    b_irq_req = 0; tick();
    b_irq_req = 1; b_new_irq = 1; b_mcause = 1; tick();
    b_new_irq = 0; b_pc_vld = 1; b_pc_adr = 32'h40; tick();
    b_pc_vld = 0;
    check("b_next_vld", 64'(b_lat_vld), 1);
    check("b_next_last", 64'(b_lat_last), 1);
    check("b_to_sticky", 64'(b_lat_timeout), 1);
    check("b_trace_cnt", 64'(b_trace_cnt), 1);

    // Instance B: saturation and out-of-range causes
    b_mcause = 3;
    for (int i = 0; i < 5; i++) begin
      b_new_irq = 1; tick();
      b_new_irq = 0; tick();
    end
    check("b_sat", 64'(b_cause_cnt), 64'h00C4);
    b_mcause = 15; b_new_irq = 1; tick();
    b_mcause = 8; tick();
    b_new_irq = 0; tick();
    check("b_oor_cause", 64'(b_cause_cnt), 64'h00C4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
